// File: rtl/sobel_grad_seq.sv
// sobel_grad_seq: computes Sobel Gx and Gy for one 3x3 window through a shared
// external 8-bit add/sub unit. Each of the 16 weighted terms goes through a
// low-byte pass, plus a high-byte +/-1 pass whenever that byte carries or borrows.
// Optional feature macro: SOBEL_MAG_EN adds a saturated |gx|+|gy| output, mag.
module sobel_grad_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [71:0] pix_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] gx,
  output logic [15:0] gy,
  output logic [7:0]  au_a,
  output logic [7:0]  au_b,
  output logic        au_sub,
  input  logic [7:0]  au_sum,
  input  logic        au_cout
`ifdef SOBEL_MAG_EN
  ,
  output logic [7:0]  mag
`endif
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state, state_next;
  logic [71:0] pix;
  logic [15:0] acc;
  logic [15:0] acc_upd;
  logic [3:0]  term;
  logic        term_sub;
  logic [7:0]  term_pix;
  logic        advance;

  // Term schedule: terms 0-7 build Gx, 8-15 build Gy; the upper half of each group subtracts
  always_comb begin
    term_sub = term[2];
    case (term)
      4'd0:    term_pix = pix[23:16];
      4'd1:    term_pix = pix[47:40];
      4'd2:    term_pix = pix[47:40];
      4'd3:    term_pix = pix[71:64];
      4'd4:    term_pix = pix[7:0];
      4'd5:    term_pix = pix[31:24];
      4'd6:    term_pix = pix[31:24];
      4'd7:    term_pix = pix[55:48];
      4'd8:    term_pix = pix[55:48];
      4'd9:    term_pix = pix[63:56];
      4'd10:   term_pix = pix[63:56];
      4'd11:   term_pix = pix[71:64];
      4'd12:   term_pix = pix[7:0];
      4'd13:   term_pix = pix[15:8];
      4'd14:   term_pix = pix[15:8];
      default: term_pix = pix[23:16];
    endcase
  end

  // Next-state logic and add/sub unit operand drive
  always_comb begin
    state_next = state;
    au_a       = 8'h00;
    au_b       = 8'h00;
    au_sub     = 1'b0;
    acc_upd    = acc;
    advance    = 1'b0;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE: begin
        if (start) state_next = LO;
      end
      LO: begin
        au_a    = acc[7:0];
        au_b    = term_pix;
        au_sub  = term_sub;
        acc_upd = {acc[15:8], au_sum};
        if (term_sub ? !au_cout : au_cout) state_next = HI;
        else advance = 1'b1;
      end
      HI: begin
        au_a    = acc[15:8];
        au_b    = 8'h01;
        au_sub  = term_sub;
        acc_upd = {au_sum, acc[7:0]};
        advance = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (advance) state_next = (term == 4'd15) ? DONE : LO;
  end

`ifdef SOBEL_MAG_EN
  logic [15:0] abs_gx, abs_gy, mag_sum;
  logic [7:0]  mag_next;

  // Saturated |gx| + |gy|, with gy taken from the value being written this edge
  always_comb begin
    abs_gx   = gx[15] ? (~gx + 16'd1) : gx;
    abs_gy   = acc_upd[15] ? (~acc_upd + 16'd1) : acc_upd;
    mag_sum  = abs_gx + abs_gy;
    mag_next = (mag_sum > 16'd255) ? 8'hFF : mag_sum[7:0];
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath: window latch, accumulator, term index and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pix  <= '0;
      acc  <= '0;
      term <= '0;
      gx   <= '0;
      gy   <= '0;
`ifdef SOBEL_MAG_EN
      mag  <= '0;
`endif
    end else if (state == IDLE && start) begin
      pix  <= pix_in;
      acc  <= '0;
      term <= '0;
    end else if (advance) begin
      if (term == 4'd7) begin
        gx   <= acc_upd;
        acc  <= '0;
        term <= 4'd8;
      end else if (term == 4'd15) begin
        gy   <= acc_upd;
        acc  <= acc_upd;
`ifdef SOBEL_MAG_EN
        mag  <= mag_next;
`endif
      end else begin
        acc  <= acc_upd;
        term <= term + 4'd1;
      end
    end else if (state == LO || state == HI) begin
      acc <= acc_upd;
    end
  end

endmodule
